cpu_debug_mem_access_seq: RTL

- Sysclk-domain consumer of the debug slave's decoded JTAG commands (jdo bus plus take_action_ocimem_a/b and take_no_action_ocimem_a strobes).
- Turns them into single-word Avalon-MM master reads and writes with an auto-incrementing address.
- Returns read data and status to the TCK-side capture path as MonDReg, monitor_ready and monitor_error.
- Sits between the debug slave wrapper and the system interconnect.

---
 rtl/cpu_debug_mem_access_seq_pkg.sv | 19 +
 rtl/cpu_debug_mem_access_seq_if.sv | 26 ++
 rtl/cpu_debug_mem_access_seq_watchdog.sv | 31 +++
 rtl/cpu_debug_mem_access_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cpu_debug_mem_access_seq_pkg.sv
// Shared types and constants for the debug memory-access sequencer.
// Covers the state encoding, the jdo field positions and the bus response codes.
package cpu_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ
  } state_t;

  localparam int JDO_ADDR_LSB   = 2;
  localparam int JDO_RDLOAD_BIT = 32;
  localparam int JDO_DATA_MSB   = 31;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD;
  localparam logic [1:0]  OKAY         = 2'b00;

endpackage

// File: rtl/cpu_debug_mem_access_seq_if.sv
// Avalon-MM single-word bus between the debug sequencer (master) and the interconnect (slave).
interface cpu_debug_mem_access_seq_if #(
  parameter int ADDR_W = 30
);

  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [1:0]        avm_response;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, avm_response
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, avm_response
  );

endinterface

// File: rtl/cpu_debug_mem_access_seq_watchdog.sv
// Per-transaction bus watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the budget of TIMEOUT_CYCLES is used up.
module cpu_debug_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_W          = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in the simulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Count k is held in the (k+1)-th busy cycle, so the last allowed cycle fires.
  assign expired = enable && !clear && (count == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_debug_mem_access_seq.sv
// Sysclk-side debug memory sequencer: turns decoded JTAG strobes into single-word
// Avalon-MM reads/writes with an auto-incrementing word address and reports status.
module cpu_debug_mem_access_seq
  import cpu_debug_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMO_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  cpu_debug_mem_access_seq_if.master avm
);

  state_t            state;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       wdata_q;
  logic              read_q;
  logic              write_q;

  logic is_idle;
  logic any_strobe;
  logic multi_strobe;
  logic go_rd;
  logic go_wr;
  logic rd_accept;
  logic rd_done;
  logic wr_done;
  logic tmo_expired;
  logic unused_jdo_bits;

  assign is_idle      = (state == ST_IDLE);
  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                      | (take_action_ocimem_a & take_no_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a);

  // Strobe priority: address load, then write, then read-next.
  assign go_rd = is_idle && (take_action_ocimem_a ? jdo[JDO_RDLOAD_BIT]
                                                  : (!take_action_ocimem_b && take_no_action_ocimem_a));
  assign go_wr = is_idle && !take_action_ocimem_a && take_action_ocimem_b;

  assign rd_accept = (state == ST_RD_REQ) && !avm.avm_waitrequest;
  assign rd_done   = (rd_accept || (state == ST_RD_WAIT)) && avm.avm_readdatavalid;
  assign wr_done   = (state == ST_WR_REQ) && !avm.avm_waitrequest;

  assign unused_jdo_bits = ^jdo[37:33];

  cpu_debug_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (go_rd | go_wr),
    .enable  (!is_idle),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      word_addr     <= '0;
      wdata_q       <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else if (is_idle) begin
      if (take_action_ocimem_a) begin
        word_addr     <= jdo[JDO_ADDR_LSB +: ADDR_W];
        monitor_error <= multi_strobe;
      end else if (take_action_ocimem_b) begin
        wdata_q <= jdo[JDO_DATA_MSB:0];
        if (multi_strobe) monitor_error <= 1'b1;
      end
      if (go_rd) begin
        state         <= ST_RD_REQ;
        read_q        <= 1'b1;
        monitor_ready <= 1'b0;
      end
      if (go_wr) begin
        state         <= ST_WR_REQ;
        write_q       <= 1'b1;
        monitor_ready <= 1'b0;
      end
    end else begin
      if (any_strobe) monitor_error <= 1'b1;
      if (tmo_expired) begin
        state         <= ST_IDLE;
        read_q        <= 1'b0;
        write_q       <= 1'b0;
        MonDReg       <= TIMEOUT_DATA;
        monitor_error <= 1'b1;
        monitor_ready <= 1'b1;
      end else begin
        if (rd_accept) begin
          read_q <= 1'b0;
          state  <= ST_RD_WAIT;
        end
        // Same-cycle readdatavalid overrides the RD_WAIT hop above.
        if (rd_done) begin
          MonDReg       <= avm.avm_readdata;
          word_addr     <= word_addr + 1'b1;
          state         <= ST_IDLE;
          monitor_ready <= 1'b1;
          if (avm.avm_response != OKAY) monitor_error <= 1'b1;
        end
        if (wr_done) begin
          write_q       <= 1'b0;
          word_addr     <= word_addr + 1'b1;
          state         <= ST_IDLE;
          monitor_ready <= 1'b1;
        end
      end
    end
  end

  assign avm.avm_address    = {word_addr, 2'b00};
  assign avm.avm_read       = read_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = 4'hF;

endmodule
